// File: rtl/data_mem_responder_pkg.sv
// Shared constants and small helpers for the data memory responder.
// Holds the default data-segment base, the ON/OFF levels and the
// counter/lane helpers used by the top level and the storage array.
package data_mem_responder_pkg;

    localparam logic [63:0] BEGINNING_DATA = 64'h0000_0000_1001_0000;
    localparam int          DEFAULT_DEPTH  = 512;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int DATA_W  = 64;
    localparam int LANES   = 8;
    localparam int CNT_W   = 32;

    localparam logic [CNT_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    // Replace only the byte lanes selected by the mask.
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_data,
                                                      input logic [DATA_W-1:0] new_data,
                                                      input logic [LANES-1:0]  lane_mask);
        logic [DATA_W-1:0] result;
        result = old_data;
        for (int k = 0; k < LANES; k++) begin
            if (lane_mask[k]) begin
                result[k*8 +: 8] = new_data[k*8 +: 8];
            end else begin
                result[k*8 +: 8] = old_data[k*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_array_64.sv
// Doubleword storage: synchronous byte-lane write and registered read.
// A read and a write to the same index in one cycle return the old
// contents (read-first). Contents are never cleared. DEPTH must be a
// power of two and at least 2.
module mem_array_64
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [AW-1:0]     index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LANES-1:0]  byte_en,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Lane-masked write; unselected lanes keep their previous bytes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[index] <= merge_lanes(mem_r[index], wr_data, byte_en);
        end
    end

    // Registered read of the pre-write contents; holds when not reading.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[index];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: address decode against a base/size window,
// one-cycle read response, sticky first-miss capture and saturating
// access counters around a single mem_array_64 instance.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = BEGINNING_DATA,
    parameter int          DEPTH     = DEFAULT_DEPTH
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [63:0] iAddress,
    input  logic [63:0] iWriteData,
    input  logic [7:0]  iByteEnable,
    output logic [63:0] oReadData,
    output logic        oReadValid,
    output logic        oError,
    output logic [63:0] oErrAddr,
    input  logic        iErrClear,
    output logic [31:0] oReadCount,
    output logic [31:0] oWriteCount
);

    localparam int          AW   = $clog2(DEPTH);
    // Window size in bytes; comparing the offset against it avoids any
    // overflow of BASE_ADDR + size near the top of the address space.
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    logic [63:0]   offset_s;
    logic          hit_s;
    logic [AW-1:0] index_s;
    logic          rd_acc_s;
    logic          wr_acc_s;
    logic          miss_s;
    logic [63:0]   mem_rd_s;

    logic          valid_r;
    logic          zero_r;
    logic          err_r;
    logic [63:0]   err_addr_r;
    logic [31:0]   read_cnt_r;
    logic [31:0]   write_cnt_r;

    // Decode: window hit, doubleword index and accepted/missed requests.
    always_comb begin
        offset_s = iAddress - BASE_ADDR;
        hit_s    = (iAddress >= BASE_ADDR) && (offset_s < SPAN);
        index_s  = offset_s[AW+2:3];
        rd_acc_s = iRST & iReadEnable & hit_s;
        wr_acc_s = iRST & iWriteEnable & hit_s;
        miss_s   = iRST & (iReadEnable | iWriteEnable) & ~hit_s;
    end

    mem_array_64 #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (iCLK),
        .rd_en   (rd_acc_s),
        .wr_en   (wr_acc_s),
        .index   (index_s),
        .wr_data (iWriteData),
        .byte_en (iByteEnable),
        .rd_data (mem_rd_s)
    );

    // Response register: valid pulse plus a flag forcing zero data after
    // reset or a read miss; the array register holds data while idle.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            valid_r <= OFF;
            zero_r  <= ON;
        end else begin
            valid_r <= iReadEnable;
            if (iReadEnable) begin
                zero_r <= ~hit_s;
            end else begin
                zero_r <= zero_r;
            end
        end
    end

    // Sticky error: a miss always sets it and captures the address when
    // no earlier error is held or the held one is being cleared now.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            err_r      <= OFF;
            err_addr_r <= 64'h0;
        end else if (miss_s) begin
            err_r <= ON;
            if (!err_r || iErrClear) begin
                err_addr_r <= iAddress;
            end
        end else if (iErrClear) begin
            err_r      <= OFF;
            err_addr_r <= 64'h0;
        end
    end

    // Saturating counters of accepted read and write hits.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            read_cnt_r  <= 32'h0;
            write_cnt_r <= 32'h0;
        end else begin
            if (rd_acc_s) begin
                read_cnt_r <= sat_inc(read_cnt_r);
            end
            if (wr_acc_s) begin
                write_cnt_r <= sat_inc(write_cnt_r);
            end
        end
    end

    assign oReadData   = zero_r ? 64'h0 : mem_rd_s;
    assign oReadValid  = valid_r;
    assign oError      = err_r;
    assign oErrAddr    = err_addr_r;
    assign oReadCount  = read_cnt_r;
    assign oWriteCount = write_cnt_r;

endmodule
